mem_port_arbiter: RTL and testbench

- Shares the single program/data memory port between two requesters: the control-unit-driven CPU access path (fetch, load/store) and the ioIn-side loader/debug path that writes program images and reads back memory.
- Sits between both requesters and the memory port in the program management system.
- Arbitrates round-robin with bounded bursts, so neither side starves.
- Sequences the one-cycle synchronous read return back to whichever requester issued the read.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the CPU path
// and the loader/debug path, with bounded bursts and per-requester read return.
module mem_port_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,

   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,

   input  logic              io_req_i,
   input  logic              io_we_i,
   input  logic [ADDR_W-1:0] io_addr_i,
   input  logic [DATA_W-1:0] io_wdata_i,
   output logic              io_gnt_o,
   output logic              io_rvalid_o,
   output logic [DATA_W-1:0] io_rdata_o,

   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,

   output logic [1:0]        owner_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      OWN_CPU = 2'b01,
      OWN_IO  = 2'b10
   } state_e;

   localparam int              CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             last_io_q, last_io_d;   // 1: loader was served last
   logic             cpu_rvalid_q, io_rvalid_q;

   // Grants depend only on the registered owner and that side's own request.
   assign cpu_gnt_o = (state_q == OWN_CPU) & cpu_req_i;
   assign io_gnt_o  = (state_q == OWN_IO)  & io_req_i;
   assign mem_en_o  = cpu_gnt_o | io_gnt_o;
   assign owner_o   = state_q;

   always_comb begin
      mem_we_o    = cpu_gnt_o & cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      if (state_q == OWN_IO) begin
         mem_we_o    = io_gnt_o & io_we_i;
         mem_addr_o  = io_addr_i;
         mem_wdata_o = io_wdata_i;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      last_io_d = last_io_q;
      unique case (state_q)
         IDLE: begin
            count_d = '0;
            if (cpu_req_i && io_req_i) begin
               state_d = last_io_q ? OWN_CPU : OWN_IO;
            end else if (cpu_req_i) begin
               state_d = OWN_CPU;
            end else if (io_req_i) begin
               state_d = OWN_IO;
            end
         end
         OWN_CPU: begin
            if (cpu_req_i) begin
               if (count_q == CNT_LAST) begin
                  count_d = '0;
                  if (io_req_i) begin
                     state_d   = OWN_IO;
                     last_io_d = 1'b0;
                  end
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end else begin
               count_d   = '0;
               last_io_d = 1'b0;
               state_d   = io_req_i ? OWN_IO : IDLE;
            end
         end
         OWN_IO: begin
            if (io_req_i) begin
               if (count_q == CNT_LAST) begin
                  count_d = '0;
                  if (cpu_req_i) begin
                     state_d   = OWN_CPU;
                     last_io_d = 1'b1;
                  end
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end else begin
               count_d   = '0;
               last_io_d = 1'b1;
               state_d   = cpu_req_i ? OWN_CPU : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         count_q      <= '0;
         last_io_q    <= 1'b1;
         cpu_rvalid_q <= 1'b0;
         io_rvalid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         last_io_q    <= last_io_d;
         cpu_rvalid_q <= cpu_gnt_o & ~cpu_we_i;
         io_rvalid_q  <= io_gnt_o & ~io_we_i;
      end
   end

   // Read data is broadcast; rvalid tells each side whether the word is theirs.
   assign cpu_rvalid_o = cpu_rvalid_q;
   assign io_rvalid_o  = io_rvalid_q;
   assign cpu_rdata_o  = mem_rdata_i;
   assign io_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences
// and a randomized run against an abstract arbitration/memory model.
module tb_mem_port_arbiter;
   localparam int MAXB = 4;
   localparam logic [15:0] CPU_A = 16'h0C00;
   localparam logic [15:0] IO_A  = 16'h0100;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
   logic [15:0] cpu_addr_i = '0, cpu_wdata_i = '0;
   logic        cpu_gnt_o, cpu_rvalid_o;
   logic [15:0] cpu_rdata_o;
   logic        io_req_i = 1'b0, io_we_i = 1'b0;
   logic [15:0] io_addr_i = '0, io_wdata_i = '0;
   logic        io_gnt_o, io_rvalid_o;
   logic [15:0] io_rdata_o;
   logic        mem_en_o, mem_we_o;
   logic [15:0] mem_addr_o, mem_wdata_o;
   logic [15:0] mem_rdata_i;
   logic [1:0]  owner_o;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(MAXB)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_wdata_i(cpu_wdata_i), .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o),
      .cpu_rdata_o(cpu_rdata_o),
      .io_req_i(io_req_i), .io_we_i(io_we_i), .io_addr_i(io_addr_i),
      .io_wdata_i(io_wdata_i), .io_gnt_o(io_gnt_o), .io_rvalid_o(io_rvalid_o),
      .io_rdata_o(io_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .owner_o(owner_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [15:0] init_val(input logic [15:0] a);
      if (a == 16'h0010) return 16'hBEEF;
      if (a == 16'h0011) return 16'hCAFE;
      return a ^ 16'h5A5A;
   endfunction

   // Synchronous memory: read data appears the cycle after an enabled read.
   bit [15:0] mem_arr [65536];
   bit        wr_flag [65536];
   always @(posedge clk_i) begin
      if (mem_en_o) begin
         if (mem_we_o) begin
            mem_arr[mem_addr_o] <= mem_wdata_o;
            wr_flag[mem_addr_o] <= 1'b1;
         end else begin
            mem_rdata_i <= wr_flag[mem_addr_o] ? mem_arr[mem_addr_o] : init_val(mem_addr_o);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      cpu_req_i = 1'b0;
      io_req_i  = 1'b0;
      rst_ni    = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
   endtask

   typedef struct {
      bit       c;
      bit       i;
      bit       ecg;
      bit       eig;
      bit [1:0] eown;
   } vec_t;
   vec_t vecs[24];

   // Random-run requester state and reference model
   bit          cp, ip, ecg, eig, erv_c, erv_i;
   logic        cwe = 1'b0, iwe = 1'b0;
   logic [15:0] ca = 16'h0200, ia = 16'h0200, cd = '0, idt = '0, erd_c, erd_i;
   logic [15:0] ref_mem [16];
   bit          rq [3];
   int          m_owner, m_run, m_last, x, y;

   initial begin
      vecs[0]  = '{0,0,0,0,2'd0};  vecs[1]  = '{1,1,0,0,2'd0};
      vecs[2]  = '{1,1,1,0,2'd1};  vecs[3]  = '{1,1,1,0,2'd1};
      vecs[4]  = '{1,1,1,0,2'd1};  vecs[5]  = '{1,1,1,0,2'd1};
      vecs[6]  = '{1,1,0,1,2'd2};  vecs[7]  = '{1,1,0,1,2'd2};
      vecs[8]  = '{1,1,0,1,2'd2};  vecs[9]  = '{1,1,0,1,2'd2};
      vecs[10] = '{1,1,1,0,2'd1};  vecs[11] = '{0,1,0,0,2'd1};
      vecs[12] = '{0,1,0,1,2'd2};  vecs[13] = '{0,0,0,0,2'd2};
      vecs[14] = '{0,1,0,0,2'd0};  vecs[15] = '{1,1,0,1,2'd2};
      vecs[16] = '{1,0,0,0,2'd2};  vecs[17] = '{1,0,1,0,2'd1};
      vecs[18] = '{1,0,1,0,2'd1};  vecs[19] = '{1,0,1,0,2'd1};
      vecs[20] = '{1,0,1,0,2'd1};  vecs[21] = '{1,0,1,0,2'd1};
      vecs[22] = '{0,0,0,0,2'd1};  vecs[23] = '{0,0,0,0,2'd0};

      // Reset held with both sides requesting
      rst_ni = 1'b0;
      cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = CPU_A; cpu_wdata_i = 16'h1111;
      io_req_i  = 1'b1; io_we_i  = 1'b1; io_addr_i  = IO_A;  io_wdata_i  = 16'h2222;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         chk("rst_cgnt", 32'(cpu_gnt_o), 0);
         chk("rst_ignt", 32'(io_gnt_o), 0);
         chk("rst_crv", 32'(cpu_rvalid_o), 0);
         chk("rst_irv", 32'(io_rvalid_o), 0);
         chk("rst_en", 32'(mem_en_o), 0);
         chk("rst_we", 32'(mem_we_o), 0);
         chk("rst_owner", 32'(owner_o), 0);
      end
      step();
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("rel_owner0", 32'(owner_o), 0);
      step();
      @(negedge clk_i);
      chk("rel_owner1", 32'(owner_o), 1);
      chk("rel_cgnt", 32'(cpu_gnt_o), 1);
      $display("txn reset-release: owner=%0d cpu_gnt=%0d", owner_o, cpu_gnt_o);

      // Directed vector table (writes only)
      do_reset();
      for (int v = 0; v < 24; v++) begin
         cpu_req_i = vecs[v].c;
         io_req_i  = vecs[v].i;
         @(negedge clk_i);
         chk($sformatf("vec%0d_cgnt", v), 32'(cpu_gnt_o), 32'(vecs[v].ecg));
         chk($sformatf("vec%0d_ignt", v), 32'(io_gnt_o), 32'(vecs[v].eig));
         chk($sformatf("vec%0d_owner", v), 32'(owner_o), 32'(vecs[v].eown));
         chk($sformatf("vec%0d_en", v), 32'(mem_en_o), 32'(vecs[v].ecg | vecs[v].eig));
         chk($sformatf("vec%0d_addr", v), 32'(mem_addr_o), 32'((vecs[v].eown == 2'd2) ? IO_A : CPU_A));
         chk($sformatf("vec%0d_rv", v), 32'({cpu_rvalid_o, io_rvalid_o}), 0);
         $display("txn vec%0d: req=%0d%0d gnt=%0d%0d owner=%0d", v, vecs[v].c, vecs[v].i,
                  cpu_gnt_o, io_gnt_o, owner_o);
         step();
      end

      // CPU alone: back-to-back reads
      do_reset();
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0010;
      @(negedge clk_i);
      chk("rd_idle_gnt", 32'(cpu_gnt_o), 0);
      step();
      @(negedge clk_i);
      chk("rd0_gnt", 32'(cpu_gnt_o), 1);
      chk("rd0_addr", 32'(mem_addr_o), 32'h0010);
      chk("rd0_we", 32'(mem_we_o), 0);
      step();
      cpu_addr_i = 16'h0011;
      @(negedge clk_i);
      chk("rd1_gnt", 32'(cpu_gnt_o), 1);
      chk("rd0_rv", 32'(cpu_rvalid_o), 1);
      chk("rd0_data", 32'(cpu_rdata_o), 32'hBEEF);
      chk("rd0_irv", 32'(io_rvalid_o), 0);
      step();
      cpu_req_i = 1'b0;
      @(negedge clk_i);
      chk("rd1_rv", 32'(cpu_rvalid_o), 1);
      chk("rd1_data", 32'(cpu_rdata_o), 32'hCAFE);
      chk("rd1_irv", 32'(io_rvalid_o), 0);
      chk("rd_end_gnt", 32'(cpu_gnt_o), 0);
      step();
      @(negedge clk_i);
      chk("rd_end_rv", 32'(cpu_rvalid_o), 0);
      $display("txn cpu reads 0x0010/0x0011 done");

      // Loader write while CPU idle
      do_reset();
      io_req_i = 1'b1; io_we_i = 1'b1; io_addr_i = 16'h0100; io_wdata_i = 16'h1234;
      @(negedge clk_i);
      chk("wr_idle_gnt", 32'(io_gnt_o), 0);
      step();
      @(negedge clk_i);
      chk("wr_gnt", 32'(io_gnt_o), 1);
      chk("wr_en", 32'(mem_en_o), 1);
      chk("wr_we", 32'(mem_we_o), 1);
      chk("wr_addr", 32'(mem_addr_o), 32'h0100);
      chk("wr_data", 32'(mem_wdata_o), 32'h1234);
      step();
      io_req_i = 1'b0;
      @(negedge clk_i);
      chk("wr_after_en", 32'(mem_en_o), 0);
      chk("wr_after_rv", 32'({cpu_rvalid_o, io_rvalid_o}), 0);
      $display("txn loader write 0x1234 @0x0100 done");

      // CPU read on the last burst slot, ownership moves to loader
      do_reset();
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0011;
      io_req_i  = 1'b1; io_we_i  = 1'b1; io_addr_i  = 16'h0100; io_wdata_i = 16'h0F0F;
      @(negedge clk_i);
      for (int k = 0; k < MAXB; k++) begin
         step();
         @(negedge clk_i);
         chk($sformatf("burst%0d_cgnt", k), 32'(cpu_gnt_o), 1);
      end
      step();
      @(negedge clk_i);
      chk("last_owner", 32'(owner_o), 2);
      chk("last_ignt", 32'(io_gnt_o), 1);
      chk("last_crv", 32'(cpu_rvalid_o), 1);
      chk("last_cdata", 32'(cpu_rdata_o), 32'hCAFE);
      chk("last_irv", 32'(io_rvalid_o), 0);
      $display("txn last-slot read returned across ownership change");

      // Reset right after an accepted read
      do_reset();
      io_req_i = 1'b0;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0010;
      step();
      @(negedge clk_i);
      chk("rstmid_gnt", 32'(cpu_gnt_o), 1);
      rst_ni = 1'b0;
      #1;
      chk("rstmid_owner", 32'(owner_o), 0);
      chk("rstmid_gnt0", 32'(cpu_gnt_o), 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         chk("rstmid_rv", 32'(cpu_rvalid_o), 0);
      end
      step();
      cpu_req_i = 1'b0;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("rstmid_rel_rv", 32'(cpu_rvalid_o), 0);
      chk("rstmid_rel_owner", 32'(owner_o), 0);
      $display("txn reset after accepted read: no return");

      // Randomized run against the reference model
      do_reset();
      for (int k = 0; k < 16; k++) ref_mem[k] = init_val(16'h0200 + 16'(k));
      cp = 0; ip = 0; erv_c = 0; erv_i = 0;
      m_owner = 0; m_run = 0; m_last = 2;
      for (int n = 0; n < 3000; n++) begin
         if (!cp && $urandom_range(3) != 0) begin
            cp = 1; cwe = 1'($urandom_range(1)); ca = 16'h0200 + 16'($urandom_range(15)); cd = 16'($urandom);
         end else if (cp && $urandom_range(15) == 0) begin
            cp = 0;
         end
         if (!ip && $urandom_range(3) != 0) begin
            ip = 1; iwe = 1'($urandom_range(1)); ia = 16'h0200 + 16'($urandom_range(15)); idt = 16'($urandom);
         end else if (ip && $urandom_range(15) == 0) begin
            ip = 0;
         end
         cpu_req_i = cp; cpu_we_i = cwe; cpu_addr_i = ca; cpu_wdata_i = cd;
         io_req_i  = ip; io_we_i  = iwe; io_addr_i  = ia; io_wdata_i  = idt;
         @(negedge clk_i);
         ecg = (m_owner == 1) && cp;
         eig = (m_owner == 2) && ip;
         chk("rnd_cgnt", 32'(cpu_gnt_o), 32'(ecg));
         chk("rnd_ignt", 32'(io_gnt_o), 32'(eig));
         chk("rnd_owner", 32'(owner_o), 32'(m_owner));
         chk("rnd_en", 32'(mem_en_o), 32'(ecg | eig));
         chk("rnd_we", 32'(mem_we_o), 32'((ecg & cwe) | (eig & iwe)));
         if (ecg || eig) chk("rnd_addr", 32'(mem_addr_o), 32'(ecg ? ca : ia));
         if ((ecg && cwe) || (eig && iwe)) chk("rnd_wdata", 32'(mem_wdata_o), 32'(ecg ? cd : idt));
         chk("rnd_crv", 32'(cpu_rvalid_o), 32'(erv_c));
         chk("rnd_irv", 32'(io_rvalid_o), 32'(erv_i));
         if (erv_c) chk("rnd_cdata", 32'(cpu_rdata_o), 32'(erd_c));
         if (erv_i) chk("rnd_idata", 32'(io_rdata_o), 32'(erd_i));
         if (ecg) $display("txn rnd%0d cpu %s addr=%h data=%h", n, cwe ? "wr" : "rd", ca, cwe ? cd : ref_mem[ca[3:0]]);
         if (eig) $display("txn rnd%0d io %s addr=%h data=%h", n, iwe ? "wr" : "rd", ia, iwe ? idt : ref_mem[ia[3:0]]);

         erv_c = ecg && !cwe;
         erv_i = eig && !iwe;
         if (erv_c) erd_c = ref_mem[ca[3:0]];
         if (erv_i) erd_i = ref_mem[ia[3:0]];
         if (ecg && cwe) ref_mem[ca[3:0]] = cd;
         if (eig && iwe) ref_mem[ia[3:0]] = idt;

         rq[1] = cp; rq[2] = ip;
         if (m_owner == 0) begin
            if (rq[1] && rq[2]) m_owner = 3 - m_last;
            else if (rq[1]) m_owner = 1;
            else if (rq[2]) m_owner = 2;
         end else begin
            x = m_owner;
            y = 3 - x;
            if (rq[x]) begin
               m_run++;
               if (m_run == MAXB) begin
                  m_run = 0;
                  if (rq[y]) begin
                     m_owner = y;
                     m_last  = x;
                  end
               end
            end else begin
               m_run   = 0;
               m_last  = x;
               m_owner = rq[y] ? y : 0;
            end
         end
         if (ecg) cp = 0;
         if (eig) ip = 0;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
